// File: rtl/servo_pkg.sv
// Shared definitions for the servo command sequencer: position codes, command
// entry layout, FSM state encoding and the dwell-load helper.
package servo_pkg;

    localparam logic [1:0] POS_CENTER = 2'b00;
    localparam logic [1:0] POS_MAX    = 2'b01;
    localparam logic [1:0] POS_MIN    = 2'b10;

    localparam int DWELL_W = 8;
    localparam int ENTRY_W = 10;

    typedef struct packed {
        logic [1:0]         pos;
        logic [DWELL_W-1:0] dwell;
    } cmd_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // A zero dwell still holds its position for one full frame.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] dwell);
        if (dwell == 8'd0) begin
            return 8'd1;
        end else begin
            return dwell;
        end
    endfunction

endpackage

// File: rtl/servo_cmd_fifo.sv
// Synchronous command FIFO with occupancy level and synchronous flush.
// Reads come straight from storage, so a pop never sees a same-cycle push.
module servo_cmd_fifo
    import servo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic [LVL_W-1:0]   level,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic               do_push_s;
    logic               do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign full      = (level_r == LVL_FULL);
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign do_push_s = push & ~full & ~flush;
    assign do_pop_s  = pop & ~empty & ~flush;
    assign dout      = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Entry storage; slots are only ever read between the two pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy, cleared by reset or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Servo command sequencer: tick/frame timebase, command FIFO and an IDLE/HOLD
// sequencer that updates the PWM position only on frame boundaries.
module servo_cmd_sequencer
    import servo_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int TICK_HZ     = 20000,
    parameter int FRAME_TICKS = 400,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_pos,
    input  logic [7:0] cmd_dwell,
    input  logic       flush,
    output logic       tick,
    output logic       frame_done,
    output logic [1:0] grados,
    output logic       servo_en,
    output logic       busy,
    output logic [2:0] fifo_level
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FRM_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(FRAME_TICKS - 1);

    logic [DIV_W-1:0]   div_cnt_r;
    logic [DIV_W-1:0]   div_next_s;
    logic [FRM_W-1:0]   frame_cnt_r;
    logic [FRM_W-1:0]   frame_next_s;
    logic               tick_r;
    logic               frame_done_r;
    logic               ready_en_r;
    state_e             state_r;
    state_e             state_next_s;
    logic [1:0]         grados_r;
    logic               servo_en_r;
    logic [DWELL_W-1:0] dwell_cnt_r;
    logic               push_s;
    logic               pop_s;
    logic               load_s;
    logic               release_s;
    logic               dec_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [ENTRY_W-1:0] fifo_dout_s;
    logic [2:0]         level_s;
    cmd_entry_t         head_s;

    // Next divider and frame counts, used to register the strobes in step with the counts.
    always_comb begin
        div_next_s   = div_cnt_r + DIV_W'(1);
        frame_next_s = frame_cnt_r;
        if (div_cnt_r == DIV_LAST) begin
            div_next_s = {DIV_W{1'b0}};
            if (frame_cnt_r == FRAME_LAST) begin
                frame_next_s = {FRM_W{1'b0}};
            end else begin
                frame_next_s = frame_cnt_r + FRM_W'(1);
            end
        end else begin
            frame_next_s = frame_cnt_r;
        end
    end

    // Free-running timebase; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r    <= {DIV_W{1'b0}};
            frame_cnt_r  <= {FRM_W{1'b0}};
            tick_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            div_cnt_r    <= div_next_s;
            frame_cnt_r  <= frame_next_s;
            tick_r       <= (div_next_s == DIV_LAST);
            frame_done_r <= (div_next_s == DIV_LAST) && (frame_next_s == FRAME_LAST);
        end
    end

    // Holds cmd_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    assign cmd_ready = ready_en_r & ~fifo_full_s & ~flush;
    assign push_s    = cmd_valid & cmd_ready;
    assign head_s    = cmd_entry_t'(fifo_dout_s);

    servo_cmd_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (3)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push_s),
        .din   ({cmd_pos, cmd_dwell}),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .level (level_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sequencer decisions; everything is gated to frame_done cycles and overridden by flush.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        release_s    = 1'b0;
        dec_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_done_r && !fifo_empty_s) begin
                    pop_s        = 1'b1;
                    load_s       = 1'b1;
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (frame_done_r && (dwell_cnt_r <= 8'd1)) begin
                    if (!fifo_empty_s) begin
                        pop_s  = 1'b1;
                        load_s = 1'b1;
                    end else begin
                        release_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end else if (frame_done_r) begin
                    dec_s = 1'b1;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
        if (flush) begin
            pop_s        = 1'b0;
            load_s       = 1'b0;
            release_s    = 1'b0;
            dec_s        = 1'b0;
            state_next_s = ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State and registered PWM-stage outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            grados_r    <= POS_CENTER;
            servo_en_r  <= 1'b0;
            dwell_cnt_r <= 8'd0;
        end else begin
            state_r <= state_next_s;
            if (flush) begin
                grados_r    <= POS_CENTER;
                servo_en_r  <= 1'b0;
                dwell_cnt_r <= 8'd0;
            end else if (load_s) begin
                grados_r    <= head_s.pos;
                servo_en_r  <= 1'b1;
                dwell_cnt_r <= dwell_load(head_s.dwell);
            end else if (release_s) begin
                servo_en_r  <= 1'b0;
                dwell_cnt_r <= 8'd0;
            end else if (dec_s) begin
                dwell_cnt_r <= dwell_cnt_r - 8'd1;
            end else begin
                dwell_cnt_r <= dwell_cnt_r;
            end
        end
    end

    assign tick       = tick_r;
    assign frame_done = frame_done_r;
    assign grados     = grados_r;
    assign servo_en   = servo_en_r;
    assign fifo_level = level_s;
    assign busy       = (state_r == ST_HOLD) || (level_s != 3'd0);

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Bench for servo_cmd_sequencer: vector table, directed corner sequences and
// randomized traffic, all checked against a queue-based reference.
module tb_servo_cmd_sequencer;
    localparam int DIV   = 4;
    localparam int FT    = 5;
    localparam int FRAME = DIV * FT;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_pos;
    logic [7:0] cmd_dwell;
    logic       flush;
    logic       tick;
    logic       frame_done;
    logic [1:0] grados;
    logic       servo_en;
    logic       busy;
    logic [2:0] fifo_level;

    always #5 clk = ~clk;

    servo_cmd_sequencer #(
        .CLK_HZ      (4),
        .TICK_HZ     (1),
        .FRAME_TICKS (FT),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_pos    (cmd_pos),
        .cmd_dwell  (cmd_dwell),
        .flush      (flush),
        .tick       (tick),
        .frame_done (frame_done),
        .grados     (grados),
        .servo_en   (servo_en),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    typedef struct {
        logic [1:0] pos;
        logic [7:0] dwell;
    } cmd_t;

    typedef struct {
        bit         valid;
        logic [1:0] pos;
        logic [7:0] dwell;
        int         frames;
        logic [1:0] gr;
        bit         en;
        bit         bsy;
        int         lvl;
    } vec_t;

    // Reference: edge count since reset release, a command queue and the held command.
    cmd_t       q[$];
    int         ecount;
    bit         ready_ok;
    bit         holding;
    int         rem;
    logic [1:0] m_gr;
    bit         m_en;
    bit         m_pushed;
    int         n_pass;
    int         n_total;
    vec_t       vt [9];
    logic [1:0] fp [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ecount   = 0;
        ready_ok = 1'b0;
        holding  = 1'b0;
        rem      = 0;
        m_gr     = 2'b00;
        m_en     = 1'b0;
        m_pushed = 1'b0;
    endtask

    task automatic step();
        bit   fd_pre;
        bit   ready_pre;
        cmd_t e;
        @(negedge clk);
        fd_pre    = (ecount % FRAME == FRAME - 1);
        ready_pre = ready_ok && (q.size() < DEPTH) && !flush;
        chk("cmd_ready", cmd_ready, ready_pre);
        @(posedge clk);
        m_pushed = 1'b0;
        if (flush) begin
            q.delete();
            holding = 1'b0;
            m_en    = 1'b0;
            m_gr    = 2'b00;
        end else begin
            if (fd_pre) begin
                if (!holding || rem == 1) begin
                    if (q.size() > 0) begin
                        e       = q.pop_front();
                        m_gr    = e.pos;
                        m_en    = 1'b1;
                        rem     = (e.dwell == 8'd0) ? 1 : int'(e.dwell);
                        holding = 1'b1;
                    end else if (holding) begin
                        holding = 1'b0;
                        m_en    = 1'b0;
                    end
                end else begin
                    rem--;
                end
            end
            if (cmd_valid && ready_pre) begin
                e.pos   = cmd_pos;
                e.dwell = cmd_dwell;
                q.push_back(e);
                m_pushed = 1'b1;
            end
        end
        ecount++;
        ready_ok = 1'b1;
        #1;
        chk("tick", tick, (ecount % DIV == DIV - 1));
        chk("frame_done", frame_done, (ecount % FRAME == FRAME - 1));
        chk("grados", grados, m_gr);
        chk("servo_en", servo_en, m_en);
        chk("fifo_level", fifo_level, q.size());
        chk("busy", busy, holding || (q.size() != 0));
    endtask

    // Advance past the next frame_done edge, where the sequencer updates.
    task automatic next_frame();
        int guard = 0;
        while ((ecount % FRAME != FRAME - 1) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        if (guard >= 2 * FRAME) chk("next_frame_timeout", 0, 1);
        step();
    endtask

    task automatic push_one(input logic [1:0] pos, input logic [7:0] dwell);
        cmd_valid = 1'b1;
        cmd_pos   = pos;
        cmd_dwell = dwell;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int k;
        int ntick;
        int nfd;
        int first_tick;
        int first_fd;
        int guard;
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_pos   = 2'b00;
        cmd_dwell = 8'd0;
        flush     = 1'b0;
        model_reset();

        vt[0] = '{1'b1, 2'b01, 8'd2, 1, 2'b01, 1'b1, 1'b1, 0};
        vt[1] = '{1'b0, 2'b00, 8'd0, 1, 2'b01, 1'b1, 1'b1, 0};
        vt[2] = '{1'b0, 2'b00, 8'd0, 1, 2'b01, 1'b0, 1'b0, 0};
        vt[3] = '{1'b1, 2'b10, 8'd1, 0, 2'b01, 1'b0, 1'b1, 1};
        vt[4] = '{1'b1, 2'b01, 8'd1, 0, 2'b01, 1'b0, 1'b1, 2};
        vt[5] = '{1'b1, 2'b00, 8'd0, 1, 2'b10, 1'b1, 1'b1, 2};
        vt[6] = '{1'b0, 2'b00, 8'd0, 1, 2'b01, 1'b1, 1'b1, 1};
        vt[7] = '{1'b0, 2'b00, 8'd0, 1, 2'b00, 1'b1, 1'b1, 0};
        vt[8] = '{1'b0, 2'b00, 8'd0, 1, 2'b00, 1'b0, 1'b0, 0};
        fp[0] = 2'b10; fp[1] = 2'b01; fp[2] = 2'b11; fp[3] = 2'b00; fp[4] = 2'b10;

        // Reset values while reset is held low.
        repeat (3) @(posedge clk);
        #3;
        chk("rst_tick", tick, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_grados", grados, 0);
        chk("rst_servo_en", servo_en, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();

        // Timebase cadence from release.
        ntick = 0; nfd = 0; first_tick = -1; first_fd = -1;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            step();
            if (tick === 1'b1) begin
                ntick++;
                if (first_tick < 0) first_tick = i;
            end
            if (frame_done === 1'b1) begin
                nfd++;
                if (first_fd < 0) first_fd = i;
            end
        end
        chk("first_tick_edge", first_tick, 3);
        chk("tick_count", ntick, 10);
        chk("first_fd_edge", first_fd, 19);
        chk("fd_count", nfd, 2);

        // Vector table: single command, then back-to-back with a zero dwell.
        for (int i = 0; i < 9; i++) begin
            cmd_valid = vt[i].valid;
            cmd_pos   = vt[i].pos;
            cmd_dwell = vt[i].dwell;
            step();
            cmd_valid = 1'b0;
            for (int f = 0; f < vt[i].frames; f++) next_frame();
            chk($sformatf("vec%0d_grados", i), grados, vt[i].gr);
            chk($sformatf("vec%0d_servo_en", i), servo_en, vt[i].en);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
            chk($sformatf("vec%0d_level", i), fifo_level, vt[i].lvl);
        end

        // Full FIFO with cmd_valid held: fifth command waits for the first pop.
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_pos   = fp[i];
            cmd_dwell = 8'd1;
            guard = 0;
            do begin
                step();
                guard++;
            end while (!m_pushed && guard < 3 * FRAME);
            if (!m_pushed) chk("full_push_timeout", 0, 1);
            if (i == 3) begin
                chk("full_cmd_ready", cmd_ready, 0);
                chk("full_level", fifo_level, 4);
            end
        end
        cmd_valid = 1'b0;
        chk("full_after5_level", fifo_level, 4);
        chk("full_after5_grados", grados, fp[0]);
        for (int j = 0; j < 4; j++) begin
            next_frame();
            chk($sformatf("full_order%0d_grados", j + 1), grados, fp[j + 1]);
            chk($sformatf("full_order%0d_level", j + 1), fifo_level, 3 - j);
            chk($sformatf("full_order%0d_servo_en", j + 1), servo_en, 1);
        end
        next_frame();
        chk("full_end_servo_en", servo_en, 0);

        // Flush mid-HOLD with two queued and a coincident cmd_valid.
        push_one(2'b01, 8'd3);
        push_one(2'b10, 8'd3);
        push_one(2'b00, 8'd3);
        next_frame();
        chk("pre_flush_level", fifo_level, 2);
        chk("pre_flush_servo_en", servo_en, 1);
        repeat (6) step();
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_pos   = 2'b11;
        cmd_dwell = 8'd5;
        step();
        chk("flush_cmd_ready", cmd_ready, 0);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        chk("flush_level", fifo_level, 0);
        chk("flush_servo_en", servo_en, 0);
        chk("flush_grados", grados, 0);
        chk("flush_busy", busy, 0);
        chk("flush_tick_phase", tick, 1);
        repeat (FRAME) step();
        chk("flush_dropped_level", fifo_level, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 800; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_pos   = 2'($urandom_range(0, 3));
            cmd_dwell = 8'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        cmd_valid = 1'b0;
        flush     = 1'b1;
        step();
        flush     = 1'b0;

        // Asynchronous reset in the middle of a HOLD.
        push_one(2'b10, 8'd3);
        next_frame();
        repeat (3) step();
        chk("pre_reset_servo_en", servo_en, 1);
        #2 reset = 1'b0;
        #1;
        chk("areset_tick", tick, 0);
        chk("areset_frame_done", frame_done, 0);
        chk("areset_grados", grados, 0);
        chk("areset_servo_en", servo_en, 0);
        chk("areset_level", fifo_level, 0);
        chk("areset_busy", busy, 0);
        chk("areset_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1 chk("areset_hold_ready", cmd_ready, 0);
        #1 reset = 1'b1;
        model_reset();
        k = 0;
        do begin
            step();
            k++;
        end while (tick !== 1'b1 && k < 2 * DIV);
        chk("post_reset_first_tick", k, 3);
        repeat (FRAME) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
